shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  EX-stage issue buffer directly upstream of the 32-bit shifter.
//  - Accepts decoded R-type shift instructions plus register operands from ID.
//  - Selects the shift amount: instr[10:6] for immediate forms, rs_data[4:0] for variable forms.
//  - Classifies the shift op and delivers {op, value, shamt, rd} over valid/ready.
//  - A 2-entry skid buffer keeps ID decoupled from shifter back-pressure at full throughput.
// PARAMETERS
//  DW     32  operand/result data width
//  SAW    5   shift-amount width (log2 DW)
//  RDW    5   destination register index width
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  flush      in   1    pipeline flush (branch/exception); kills all buffered entries
//  in_valid   in   1    ID presents an instruction
//  in_ready   out  1    stage can accept this cycle
//  instr      in   32   MIPS instruction word
//  rs_data    in   DW   GPR[rs]
//  rt_data    in   DW   GPR[rt], the value to be shifted
//  out_valid  out  1    entry presented to the shifter
//  out_ready  in   1    shifter consumes this cycle
//  out_op     out  2    00 = SLL, 01 = SRL, 11 = SRA (10 is never driven)
//  out_value  out  DW   value to shift (rt_data)
//  out_shamt  out  SAW  shift amount
//  out_rd     out  RDW  destination register (instr[15:11])
//  drop_cnt   out  16   count of accepted non-shift instructions; saturates at 0xFFFF
// BEHAVIOUR
//  - Reset (rst = 1 at a clk edge):
//    - both entries invalid; out_valid = 0; in_ready = 1; drop_cnt = 0.
//    - out_op, out_value, out_shamt, out_rd = 0.
//  - Decode (combinational on the input side): a shift is opcode instr[31:26] = 0 with funct in:
//    - 000000 SLL, 000010 SRL, 000011 SRA: shamt = instr[10:6].
//    - 000100 SLLV, 000110 SRLV, 000111 SRAV: shamt = rs_data[4:0].
//    - Variable forms use only the low SAW bits of rs_data; upper bits are ignored.
//  - Accept = in_valid & in_ready.
//    - Shift: the entry is pushed.
//    - Non-shift: consumed and discarded, drop_cnt++ (saturating); nothing is pushed.
//  - Latency: with the buffer empty, an entry accepted at edge N has out_valid = 1 after edge N.
//    - There is no combinational in->out path.
//  - Entries: main (drives out_*) and skid.
//    - in_ready is registered and equals !skid_valid.
//    - Pop = out_valid & out_ready. out_* stay stable while out_valid & !out_ready.
//  - Occupancy state machine:
//    - EMPTY: push -> ONE.
//    - ONE:
//      - push & pop -> ONE (main is replaced by the new entry).
//      - push only -> TWO (new entry goes to skid).
//      - pop only -> EMPTY.
//    - TWO (in_ready = 0):
//      - pop -> ONE (skid moves to main).
//      - A push cannot occur.
//  - Order: strict FIFO; the skid entry never overtakes main.
//  - flush = 1 at an edge:
//    - both entries are cleared -> EMPTY; in_ready = 1 the next cycle.
//    - in_valid in the same cycle is ignored: no push, no drop_cnt change.
//    - flush overrides a simultaneous pop.
//  - rst has priority over flush.
//  - Reset mid-operation discards all entries with no output pulse.
//  - rd = 0 and shamt = 0 are forwarded unmodified; the shifter handles them.
// STRUCTURE
//  - Package shift_pkg:
//    - funct constants FN_SLL / FN_SRL / FN_SRA / FN_SLLV / FN_SRLV / FN_SRAV, OPC_RTYPE.
//    - op encodings OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b11.
//    - a packed entry typedef {op, value, shamt, rd}.
//  - Sub-module shift_skid_buf: generic 2-entry valid/ready skid buffer with flush, parameterised on entry width.
//  - Top level = decode, shamt mux, drop counter, one shift_skid_buf instance.
// TESTING
//  1. SRA: instr = 0x00081903, rt_data = 0x8000_0000, buffer empty, out_ready = 1
//     -> next cycle out_valid = 1, out_op = 11, out_shamt = 4, out_rd = 3, out_value = 0x8000_0000.
//  2. SRAV: instr = 0x00081907, rs_data = 0xFFFF_FFE5
//     -> out_shamt = 5 (low bits only), out_op = 11.
//  3. Back-pressure: out_ready = 0, three back-to-back pushes A, B, C
//     -> A held on out_*; B in skid; in_ready = 0, so C is stalled.
//     -> Raise out_ready: outputs A, B, C in order on consecutive cycles, nothing lost or duplicated.
//  4. Drop: instr = 0x00000020 (ADD), then 0x8C00_0000 (LW)
//     -> no out_valid, drop_cnt = 2.
//  5. Flush: buffer in TWO, then flush = 1 with in_valid = 1
//     -> next cycle out_valid = 0, in_ready = 1, drop_cnt unchanged.
//  6. Reset while out_valid = 1 and out_ready = 0
//     -> after the edge, all outputs are 0 and in_ready = 1.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, entry layout and occupancy states for the shift issue stage
package shift_pkg;
  localparam int DW  = 32;
  localparam int SAW = 5;
  localparam int RDW = 5;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] FN_SLL    = 6'b000000;
  localparam logic [5:0] FN_SRL    = 6'b000010;
  localparam logic [5:0] FN_SRA    = 6'b000011;
  localparam logic [5:0] FN_SLLV   = 6'b000100;
  localparam logic [5:0] FN_SRLV   = 6'b000110;
  localparam logic [5:0] FN_SRAV   = 6'b000111;
  localparam logic [1:0] OP_SLL    = 2'b00;
  localparam logic [1:0] OP_SRL    = 2'b01;
  localparam logic [1:0] OP_SRA    = 2'b11;
  typedef struct packed {
    logic [1:0]     op;
    logic [DW-1:0]  value;
    logic [SAW-1:0] shamt;
    logic [RDW-1:0] rd;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
endpackage

// File: rtl/shift_skid_buf.sv
// shift_skid_buf: 2-entry valid/ready skid buffer with flush, strict FIFO order
module shift_skid_buf
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);
  occ_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic push, pop;
  assign push_ready_o = state_q != TWO;
  assign pop_valid_o  = state_q != EMPTY;
  assign pop_data_o   = main_q;
  assign push = push_valid_i & push_ready_o;
  assign pop  = pop_valid_o & pop_ready_i;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        main_d  = push_data_i;
      end
      ONE: if (push) begin
        state_d = pop ? ONE : TWO;
        main_d  = pop ? push_data_i : main_q;
        skid_d  = pop ? skid_q : push_data_i;
      end else if (pop) begin
        state_d = EMPTY;
      end
      TWO: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes R-type shifts, selects shamt, counts drops, buffers entries for the shifter
module shift_issue_stage
  import shift_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_op,
  output logic [DW-1:0]  out_value,
  output logic [SAW-1:0] out_shamt,
  output logic [RDW-1:0] out_rd,
  output logic [15:0]    drop_cnt
);
  logic [5:0] opc, fn;
  logic is_shift, accept;
  logic [15:0] drop_q, drop_d;
  entry_t in_e, out_e;
  logic unused_bits;
  assign unused_bits = ^{instr[25:16], rs_data[DW-1:SAW]};
  assign opc = instr[31:26];
  assign fn  = instr[5:0];
  assign is_shift = opc == OPC_RTYPE &&
                    (fn == FN_SLL  || fn == FN_SRL  || fn == FN_SRA ||
                     fn == FN_SLLV || fn == FN_SRLV || fn == FN_SRAV);
  assign accept = in_valid & in_ready & ~flush;
  always_comb begin
    in_e.op    = fn[1:0] == 2'b11 ? OP_SRA : fn[1] ? OP_SRL : OP_SLL;
    in_e.value = rt_data;
    in_e.shamt = fn[2] ? rs_data[SAW-1:0] : instr[10:6];
    in_e.rd    = instr[15:11];
    drop_d     = accept & ~is_shift & ~&drop_q ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= flush ? drop_q : drop_d;
  end
  shift_skid_buf #(.W($bits(entry_t))) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_valid_i (in_valid & is_shift & ~flush),
    .push_ready_o (in_ready),
    .push_data_i  (in_e),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (out_e)
  );
  assign out_op    = out_e.op;
  assign out_value = out_e.value;
  assign out_shamt = out_e.shamt;
  assign out_rd    = out_e.rd;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed vector table plus hand sequences for back-pressure, flush and reset
module tb_shift_issue_stage;
  logic        clk = 0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rs_data, rt_data, out_value;
  logic [1:0]  out_op;
  logic [4:0]  out_shamt, out_rd;
  logic [15:0] drop_cnt;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  shift_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_value(out_value), .out_shamt(out_shamt), .out_rd(out_rd),
    .drop_cnt(drop_cnt)
  );
  typedef struct {
    logic [31:0] instr, rs, rt;
    logic        v;
    logic [1:0]  op;
    logic [4:0]  sh, rd;
    logic [31:0] val;
    logic [15:0] drop;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [31:0] i);
    instr = i; in_valid = 1;
  endtask
  initial begin
    logic [4:0] pops[4];
    int n_pop;
    logic acc;
    logic [15:0] d0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    instr = 0; rs_data = 0; rt_data = 0;
    vecs[0] = '{32'h00081903, 32'h0,        32'h80000000, 1, 2'b11, 5'd4,  5'd3,  32'h80000000, 16'd0};
    vecs[1] = '{32'h00081907, 32'hFFFFFFE5, 32'h12345678, 1, 2'b11, 5'd5,  5'd3,  32'h12345678, 16'd0};
    vecs[2] = '{32'h00002FC0, 32'hFFFFFFFF, 32'h00000001, 1, 2'b00, 5'd31, 5'd5,  32'h00000001, 16'd0};
    vecs[3] = '{32'h0000F802, 32'h0000001F, 32'hDEADBEEF, 1, 2'b01, 5'd0,  5'd31, 32'hDEADBEEF, 16'd0};
    vecs[4] = '{32'h000001C4, 32'h00000020, 32'hCAFEF00D, 1, 2'b00, 5'd0,  5'd0,  32'hCAFEF00D, 16'd0};
    vecs[5] = '{32'h00005006, 32'h0000001F, 32'h0000FFFF, 1, 2'b01, 5'd31, 5'd10, 32'h0000FFFF, 16'd0};
    vecs[6] = '{32'h00000020, 32'h0,        32'h0,        0, 2'b00, 5'd0,  5'd0,  32'h0,        16'd1};
    vecs[7] = '{32'h8C000000, 32'h0,        32'h0,        0, 2'b00, 5'd0,  5'd0,  32'h0,        16'd2};
    vecs[8] = '{32'h04000003, 32'h0,        32'h0,        0, 2'b00, 5'd0,  5'd0,  32'h0,        16'd3};
    vecs[9] = '{32'h00081903, 32'h0,        32'h0F0F0F0F, 1, 2'b11, 5'd4,  5'd3,  32'h0F0F0F0F, 16'd3};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", {out_op, out_value, out_shamt, out_rd}, 0);
    @(negedge clk);
    rst = 0; out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(vecs[k].instr); rs_data = vecs[k].rs; rt_data = vecs[k].rt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), out_valid, vecs[k].v);
      chk($sformatf("v%0d_drop", k), drop_cnt, vecs[k].drop);
      if (vecs[k].v) begin
        chk($sformatf("v%0d_op", k), out_op, vecs[k].op);
        chk($sformatf("v%0d_shamt", k), out_shamt, vecs[k].sh);
        chk($sformatf("v%0d_rd", k), out_rd, vecs[k].rd);
        chk($sformatf("v%0d_value", k), out_value, vecs[k].val);
      end
    end
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    out_ready = 0; drive(32'h00000800); rs_data = 0; rt_data = 32'hA;
    @(posedge clk); #1;
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_rd", out_rd, 1);
    @(negedge clk);
    drive(32'h00001000); rt_data = 32'hB;
    @(posedge clk); #1;
    chk("bp_b_ready", in_ready, 0);
    chk("bp_b_rd", out_rd, 1);
    @(negedge clk);
    drive(32'h00001800); rt_data = 32'hC;
    @(posedge clk); #1;
    chk("bp_c_ready", in_ready, 0);
    chk("bp_c_rd", out_rd, 1);
    n_pop = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1;
      if (out_valid) begin
        if (n_pop < 4) pops[n_pop] = out_rd;
        n_pop++;
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 0;
    end
    chk("bp_in_sent", in_valid, 0);
    chk("bp_npop", n_pop, 3);
    chk("bp_pop0", pops[0], 1);
    chk("bp_pop1", pops[1], 2);
    chk("bp_pop2", pops[2], 3);
    @(negedge clk);
    out_ready = 0; drive(32'h00000800);
    repeat (2) @(posedge clk);
    #1;
    chk("fl_two_ready", in_ready, 0);
    d0 = drop_cnt;
    @(negedge clk);
    flush = 1; drive(32'h00000020);
    @(posedge clk); #1;
    chk("fl_two_valid", out_valid, 0);
    chk("fl_two_inready", in_ready, 1);
    chk("fl_two_drop", drop_cnt, d0);
    @(negedge clk);
    flush = 0; drive(32'h00000800);
    @(posedge clk); #1;
    chk("fl_one_valid_pre", out_valid, 1);
    @(negedge clk);
    flush = 1; out_ready = 1; drive(32'h00001000);
    @(posedge clk); #1;
    chk("fl_one_valid", out_valid, 0);
    @(negedge clk);
    drive(32'h00000020);
    @(posedge clk); #1;
    chk("fl_empty_drop", drop_cnt, d0);
    chk("fl_empty_valid", out_valid, 0);
    @(negedge clk);
    flush = 0; out_ready = 0; drive(32'h00081903); rt_data = 32'h55;
    @(posedge clk); #1;
    in_valid = 0;
    chk("rr_valid_pre", out_valid, 1);
    chk("rr_drop_pre", drop_cnt, 3);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("rr_valid", out_valid, 0);
    chk("rr_ready", in_ready, 1);
    chk("rr_drop", drop_cnt, 0);
    chk("rr_data", {out_op, out_value, out_shamt, out_rd}, 0);
    @(negedge clk);
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
